sample_fifo_mc: RTL and testbench
=================================

Name: sample_fifo_mc

Overview:
Multi-lane, parametrised successor of the sample read FIFO.
- Holds a sample buffer in inferred single-clock dual-port RAM; each entry packs LANES samples of WIDTH bits.
- The tree-evaluation datapath pops whole entries. A host-side write/readback port fills the buffer.
- Adds a programmable read latency, a loop (replay) mode with pass counting, and a flush of in-flight reads on pointer reset.

Parameters:
WIDTH, 16, bits per sample
LANES, 4, samples per entry (power of 2, 1..8)
DEPTH_BIT, 13, log2 of entries
RD_LAT, 2, RAM read latency in cycles (1..4)
PASS_BIT, 8, width of loop pass counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_pop  in  1  request next entry
o_front  out  LANES*WIDTH  popped entry; lane 0 in LSBs
o_vld  out  1  o_front valid this cycle
o_is_empty  out  1  threshold reached on final pass
i_ptr_rst  in  1  sync clear of pointer, pass count, empty, pipeline
i_thsh_val  in  DEPTH_BIT  entries-1 of buffer content
i_thsh_vld  in  1  load i_thsh_val
o_thsh_done  out  1  threshold load acknowledged
i_loop_en  in  1  replay mode enable (sampled when i_thsh_vld)
i_loop_cnt  in  PASS_BIT  passes-1 in loop mode (sampled when i_thsh_vld)
o_pass_cnt  out  PASS_BIT  completed passes
i_wr_en  in  1  host write strobe
i_wr_addr  in  DEPTH_BIT+log2(LANES)  sample address {entry, lane}
i_wr_data  in  WIDTH  sample to write
i_rd_en  in  1  host readback strobe
o_rd_data  out  WIDTH  readback sample, valid RD_LAT cycles after i_rd_en

Behaviour:
- Reset (rst_n low, async): o_front=0, o_vld=0, o_is_empty=0, o_thsh_done=0, o_pass_cnt=0, rptr=0, thsh=0, loop_en=0, loop_cnt=0, pipeline cleared.
- Threshold load: i_thsh_vld registers thsh, loop_en, loop_cnt; o_thsh_done pulses exactly 1 cycle, 1 cycle later. The new value applies from the cycle after i_thsh_vld.
- Accepted pop: acc = i_pop & !o_is_empty & !i_ptr_rst.
- Pop when empty is ignored: no pointer change, no o_vld.
- Pointer:
  - Each acc increments rptr.
  - If rptr==thsh at acc in loop mode and passes remain: rptr wraps to 0 and o_pass_cnt increments.
  - rptr never exceeds thsh in loop mode. It wraps at 2^DEPTH_BIT in one-shot mode.
- Empty:
  - Set on acc with rptr==thsh when loop_en=0, or when loop_en=1 and o_pass_cnt==loop_cnt.
  - Sticky until i_ptr_rst.
  - The final o_pass_cnt is loop_cnt+1 in loop mode and 0 in one-shot mode.
- Read path:
  - rptr drives the RAM read address; data is registered into o_front.
  - o_vld = acc delayed RD_LAT+1 cycles.
  - o_front holds its last value when no valid arrives.
  - Back-to-back pops give one entry per cycle.
- i_ptr_rst:
  - Highest priority; overrides a same-cycle pop.
  - Zeroes rptr, o_pass_cnt, o_is_empty and o_front next cycle.
  - Kills all in-flight valids: no o_vld occurs for pops issued before it.
  - Does not clear thsh/loop settings.
- Host port:
  - i_wr_en writes lane i_wr_addr[log2(LANES)-1:0] of entry i_wr_addr[MSB:log2(LANES)] via per-lane write enable.
  - Readback returns the addressed lane.
  - Write and pop to the same entry in the same cycle: read-first, so the pop returns old data.
- Widths: all counters are unsigned and wrap modulo 2^width, with no saturation.

Test Plan:
- Fill 8 entries (LANES=4, write samples 0..31), load thsh=7 with loop_en=0, pop continuously for 10 cycles.
  - o_thsh_done pulses once.
  - 8 o_vld pulses; first o_front=0x0003_0002_0001_0000 exactly RD_LAT+1 cycles after the first pop.
  - o_is_empty rises the cycle after the 8th pop; the last 2 pops produce no o_vld.
- Loop mode: thsh=3, loop_cnt=2, pop 14 cycles.
  - Exactly 12 o_vld, with entries 0,1,2,3 repeated three times.
  - o_pass_cnt ends at 3; o_is_empty=1.
- Pop 3 entries, then assert i_ptr_rst together with a 4th pop.
  - No o_vld after the i_ptr_rst cycle; o_front=0.
  - rptr restarts so the next pop returns entry 0.
- Same-cycle i_wr_en to entry 0 lane 0 (value 0xBEEF) and first pop.
  - Popped lane 0 = old value.
  - Readback of address 0 afterwards = 0xBEEF.
- Assert rst_n low mid-stream between clock edges.
  - All outputs are 0 immediately (async), before the next clk edge.
- Change thsh from 7 to 2 while rptr=1.
  - o_is_empty is set on the pop at rptr=2.

Source files
------------

// File: rtl/sample_fifo_mc_if.sv
// Bundle of the pop stream, threshold/loop control and host RAM port of sample_fifo_mc.
// Pop handshake: a pop is taken when i_pop=1, o_is_empty=0 and i_ptr_rst=0; o_vld marks o_front for one cycle, no backpressure.
interface sample_fifo_mc_if #(
    parameter int WIDTH     = 16,
    parameter int LANES     = 4,
    parameter int DEPTH_BIT = 13,
    parameter int PASS_BIT  = 8
);
    localparam int ADDR_W = DEPTH_BIT + $clog2(LANES);

    logic                   i_pop;
    logic [LANES*WIDTH-1:0] o_front;
    logic                   o_vld;
    logic                   o_is_empty;
    logic                   i_ptr_rst;
    logic [DEPTH_BIT-1:0]   i_thsh_val;
    logic                   i_thsh_vld;
    logic                   o_thsh_done;
    logic                   i_loop_en;
    logic [PASS_BIT-1:0]    i_loop_cnt;
    logic [PASS_BIT-1:0]    o_pass_cnt;
    logic                   i_wr_en;
    logic [ADDR_W-1:0]      i_wr_addr;
    logic [WIDTH-1:0]       i_wr_data;
    logic                   i_rd_en;
    logic [WIDTH-1:0]       o_rd_data;

    modport master (
        output i_pop, i_ptr_rst, i_thsh_val, i_thsh_vld, i_loop_en, i_loop_cnt,
        output i_wr_en, i_wr_addr, i_wr_data, i_rd_en,
        input  o_front, o_vld, o_is_empty, o_thsh_done, o_pass_cnt, o_rd_data
    );

    modport slave (
        input  i_pop, i_ptr_rst, i_thsh_val, i_thsh_vld, i_loop_en, i_loop_cnt,
        input  i_wr_en, i_wr_addr, i_wr_data, i_rd_en,
        output o_front, o_vld, o_is_empty, o_thsh_done, o_pass_cnt, o_rd_data
    );
endinterface

// File: rtl/sample_fifo_mc.sv
// Multi-lane sample read FIFO: RAM-backed entries of LANES samples, popped in order with
// programmable read latency, optional replay passes, and a host write/readback port.
module sample_fifo_mc #(
    parameter int WIDTH     = 16,
    parameter int LANES     = 4,
    parameter int DEPTH_BIT = 13,
    parameter int RD_LAT    = 2,
    parameter int PASS_BIT  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    sample_fifo_mc_if.slave  bus
);
    localparam int LANE_BIT = $clog2(LANES);
    localparam int LANE_W   = (LANE_BIT == 0) ? 1 : LANE_BIT;
    localparam int ADDR_W   = DEPTH_BIT + LANE_BIT;
    localparam int DEPTH    = 1 << DEPTH_BIT;
    localparam int FW       = LANES * WIDTH;

    logic [WIDTH-1:0]     mem [LANES][DEPTH];

    logic [DEPTH_BIT-1:0] rptr;
    logic [DEPTH_BIT-1:0] thsh;
    logic                 loop_en;
    logic [PASS_BIT-1:0]  loop_cnt;
    logic [PASS_BIT-1:0]  pass_cnt;
    logic                 is_empty;
    logic                 thsh_done;

    logic                 acc;
    logic                 at_end;
    logic                 more_passes;

    logic [DEPTH_BIT-1:0] wr_entry;
    logic [LANE_W-1:0]    wr_lane;
    logic [FW-1:0]        entry_rd;

    logic [RD_LAT-1:0]    vpipe;
    logic [FW-1:0]        dpipe [RD_LAT];
    logic [WIDTH-1:0]     rb_pipe [RD_LAT];
    logic [FW-1:0]        front;
    logic                 vld;

    assign acc         = bus.i_pop & ~is_empty & ~bus.i_ptr_rst;
    assign at_end      = (rptr == thsh);
    assign more_passes = loop_en && (pass_cnt != loop_cnt);

    assign wr_entry = DEPTH_BIT'(bus.i_wr_addr >> LANE_BIT);
    assign wr_lane  = LANE_W'(bus.i_wr_addr % ADDR_W'(LANES));

    // Host port: one lane of one entry per write, via per-lane enable.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (bus.i_wr_en && (wr_lane == LANE_W'(l))) begin
                mem[l][wr_entry] <= bus.i_wr_data;
            end
        end
    end

    always_comb begin
        entry_rd = '0;
        for (int l = 0; l < LANES; l++) begin
            entry_rd[l*WIDTH +: WIDTH] = mem[l][rptr];
        end
    end

    // Pointer, pass counting and sticky empty; i_ptr_rst wins over a same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr      <= '0;
            thsh      <= '0;
            loop_en   <= 1'b0;
            loop_cnt  <= '0;
            pass_cnt  <= '0;
            is_empty  <= 1'b0;
            thsh_done <= 1'b0;
        end else begin
            thsh_done <= bus.i_thsh_vld;
            if (bus.i_thsh_vld) begin
                thsh     <= bus.i_thsh_val;
                loop_en  <= bus.i_loop_en;
                loop_cnt <= bus.i_loop_cnt;
            end
            if (bus.i_ptr_rst) begin
                rptr     <= '0;
                pass_cnt <= '0;
                is_empty <= 1'b0;
            end else if (acc) begin
                if (!at_end) begin
                    rptr <= rptr + DEPTH_BIT'(1);
                end else if (more_passes) begin
                    rptr     <= '0;
                    pass_cnt <= pass_cnt + PASS_BIT'(1);
                end else begin
                    is_empty <= 1'b1;
                    if (loop_en) begin
                        rptr     <= '0;
                        pass_cnt <= pass_cnt + PASS_BIT'(1);
                    end else begin
                        rptr <= rptr + DEPTH_BIT'(1);
                    end
                end
            end
        end
    end

    // Read pipeline: RAM data taken at the pop edge, RD_LAT stages, then the o_front register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                dpipe[k] <= '0;
            end
            vld   <= 1'b0;
            front <= '0;
        end else begin
            for (int k = RD_LAT - 1; k > 0; k--) begin
                dpipe[k] <= dpipe[k-1];
            end
            dpipe[0] <= entry_rd;
            if (bus.i_ptr_rst) begin
                vpipe <= '0;
                vld   <= 1'b0;
                front <= '0;
            end else begin
                for (int k = RD_LAT - 1; k > 0; k--) begin
                    vpipe[k] <= vpipe[k-1];
                end
                vpipe[0] <= acc;
                vld      <= vpipe[RD_LAT-1];
                if (vpipe[RD_LAT-1]) begin
                    front <= dpipe[RD_LAT-1];
                end
            end
        end
    end

    // Readback: the first stage only loads on i_rd_en, so the result holds afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                rb_pipe[k] <= '0;
            end
        end else begin
            for (int k = RD_LAT - 1; k > 0; k--) begin
                rb_pipe[k] <= rb_pipe[k-1];
            end
            if (bus.i_rd_en) begin
                rb_pipe[0] <= mem[wr_lane][wr_entry];
            end
        end
    end

    assign bus.o_front     = front;
    assign bus.o_vld       = vld;
    assign bus.o_is_empty  = is_empty;
    assign bus.o_thsh_done = thsh_done;
    assign bus.o_pass_cnt  = pass_cnt;
    assign bus.o_rd_data   = rb_pipe[RD_LAT-1];
endmodule

// File: tb/tb_sample_fifo_mc.sv
// Directed bench for sample_fifo_mc: pop scenario table plus hand sequences for
// latency, pointer reset, read-first collision, threshold change and async reset.
module tb_sample_fifo_mc;
    localparam int WIDTH     = 16;
    localparam int LANES     = 4;
    localparam int DEPTH_BIT = 13;
    localparam int RD_LAT    = 2;
    localparam int PASS_BIT  = 8;
    localparam int ADDR_W    = DEPTH_BIT + 2;
    localparam int FW        = LANES * WIDTH;

    typedef struct {
        int thsh;
        bit loop_en;
        int loop_cnt;
        int npops;
        int exp_vld;
        int exp_pass;
        bit exp_empty;
    } scen_t;

    typedef struct {
        int addr;
        int exp_data;
    } rb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int errors = 0;
    int checks = 0;
    int vld_count = 0;
    logic [FW-1:0]    exp_q[$];
    logic [WIDTH-1:0] model_mem [32];

    sample_fifo_mc_if #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH_BIT(DEPTH_BIT), .PASS_BIT(PASS_BIT)) bus ();

    sample_fifo_mc #(
        .WIDTH(WIDTH), .LANES(LANES), .DEPTH_BIT(DEPTH_BIT), .RD_LAT(RD_LAT), .PASS_BIT(PASS_BIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] entry_val(input int e);
        logic [FW-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++) begin
            v[l*WIDTH +: WIDTH] = model_mem[e*LANES + l];
        end
        return v;
    endfunction

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n && bus.o_vld === 1'b1) begin
            vld_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vld: got o_vld with front %h expected no o_vld", bus.o_front);
            end else begin
                check("front", bus.o_front, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ptr_rst();
        bus.i_ptr_rst = 1'b1;
        step();
        bus.i_ptr_rst = 1'b0;
    endtask

    task automatic load_thsh(input int t, input bit le, input int lc);
        bus.i_thsh_val = DEPTH_BIT'(t);
        bus.i_loop_en  = le;
        bus.i_loop_cnt = PASS_BIT'(lc);
        bus.i_thsh_vld = 1'b1;
        step();
        bus.i_thsh_vld = 1'b0;
        check("thsh_done_pulse", 64'(bus.o_thsh_done), 64'd1);
        step();
        check("thsh_done_end", 64'(bus.o_thsh_done), 64'd0);
    endtask

    task automatic wr(input int addr, input int data);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_addr = ADDR_W'(addr);
        bus.i_wr_data = WIDTH'(data);
        step();
        bus.i_wr_en = 1'b0;
        model_mem[addr] = WIDTH'(data);
    endtask

    task automatic readback(input int addr, input int exp);
        bus.i_rd_en   = 1'b1;
        bus.i_wr_addr = ADDR_W'(addr);
        step();
        bus.i_rd_en = 1'b0;
        repeat (RD_LAT - 1) step();
        check("readback", 64'(bus.o_rd_data), 64'(exp));
    endtask

    task automatic drain();
        repeat (RD_LAT + 3) step();
        check("drain_missing_vld", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_front"}, bus.o_front, 64'd0);
        check({tag, "_vld"}, 64'(bus.o_vld), 64'd0);
        check({tag, "_empty"}, 64'(bus.o_is_empty), 64'd0);
        check({tag, "_thsh_done"}, 64'(bus.o_thsh_done), 64'd0);
        check({tag, "_pass_cnt"}, 64'(bus.o_pass_cnt), 64'd0);
        check({tag, "_rd_data"}, 64'(bus.o_rd_data), 64'd0);
    endtask

    initial begin
        scen_t scen [6];
        rb_t   rbv  [5];

        scen[0] = '{thsh: 7, loop_en: 0, loop_cnt: 0, npops: 10, exp_vld: 8,  exp_pass: 0, exp_empty: 1};
        scen[1] = '{thsh: 3, loop_en: 1, loop_cnt: 2, npops: 14, exp_vld: 12, exp_pass: 3, exp_empty: 1};
        scen[2] = '{thsh: 0, loop_en: 0, loop_cnt: 0, npops: 3,  exp_vld: 1,  exp_pass: 0, exp_empty: 1};
        scen[3] = '{thsh: 1, loop_en: 1, loop_cnt: 0, npops: 5,  exp_vld: 2,  exp_pass: 1, exp_empty: 1};
        scen[4] = '{thsh: 5, loop_en: 0, loop_cnt: 0, npops: 3,  exp_vld: 3,  exp_pass: 0, exp_empty: 0};
        scen[5] = '{thsh: 2, loop_en: 1, loop_cnt: 1, npops: 4,  exp_vld: 4,  exp_pass: 1, exp_empty: 0};
        rbv[0] = '{addr: 0,  exp_data: 0};
        rbv[1] = '{addr: 5,  exp_data: 5};
        rbv[2] = '{addr: 17, exp_data: 17};
        rbv[3] = '{addr: 31, exp_data: 31};
        rbv[4] = '{addr: 2,  exp_data: 2};

        bus.i_pop = 1'b0;      bus.i_ptr_rst = 1'b0;
        bus.i_thsh_val = '0;   bus.i_thsh_vld = 1'b0;
        bus.i_loop_en = 1'b0;  bus.i_loop_cnt = '0;
        bus.i_wr_en = 1'b0;    bus.i_wr_addr = '0;
        bus.i_wr_data = '0;    bus.i_rd_en = 1'b0;
        for (int i = 0; i < 32; i++) model_mem[i] = '0;

        #2 rst_n = 1'b0;
        repeat (2) step();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 32; i++) wr(i, i);
        for (int i = 0; i < 5; i++) readback(rbv[i].addr, rbv[i].exp_data);

        // first-pop latency and empty timing, thsh=7 one-shot
        do_ptr_rst();
        load_thsh(7, 1'b0, 0);
        vld_count = 0;
        for (int e = 0; e < 8; e++) exp_q.push_back(entry_val(e));
        bus.i_pop = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 2) check("lat_no_vld_yet", 64'(bus.o_vld), 64'd0);
            if (i == 3) begin
                check("lat_vld", 64'(bus.o_vld), 64'd1);
                check("lat_front0", bus.o_front, 64'h0003_0002_0001_0000);
            end
            if (i == 7) check("empty_before_8th", 64'(bus.o_is_empty), 64'd0);
            if (i == 8) check("empty_after_8th", 64'(bus.o_is_empty), 64'd1);
        end
        bus.i_pop = 1'b0;
        drain();
        check("oneshot_vld_count", 64'(vld_count), 64'd8);

        // scenario table
        for (int s = 0; s < 6; s++) begin
            int n;
            int passes;
            do_ptr_rst();
            load_thsh(scen[s].thsh, scen[s].loop_en, scen[s].loop_cnt);
            vld_count = 0;
            n = 0;
            passes = scen[s].loop_en ? scen[s].loop_cnt + 1 : 1;
            for (int p = 0; p < passes; p++) begin
                for (int e = 0; e <= scen[s].thsh; e++) begin
                    if (n < scen[s].npops) begin
                        exp_q.push_back(entry_val(e));
                        n++;
                    end
                end
            end
            bus.i_pop = 1'b1;
            repeat (scen[s].npops) step();
            bus.i_pop = 1'b0;
            drain();
            check($sformatf("scen%0d_vld_count", s), 64'(vld_count), 64'(scen[s].exp_vld));
            check($sformatf("scen%0d_pass_cnt", s), 64'(bus.o_pass_cnt), 64'(scen[s].exp_pass));
            check($sformatf("scen%0d_empty", s), 64'(bus.o_is_empty), 64'(scen[s].exp_empty));
        end

        // pointer reset together with the 4th pop
        do_ptr_rst();
        load_thsh(7, 1'b0, 0);
        vld_count = 0;
        exp_q.push_back(entry_val(0));
        bus.i_pop = 1'b1;
        repeat (3) step();
        bus.i_ptr_rst = 1'b1;
        step();
        bus.i_ptr_rst = 1'b0;
        bus.i_pop = 1'b0;
        check("prst_front_zero", bus.o_front, 64'd0);
        check("prst_vld_zero", 64'(bus.o_vld), 64'd0);
        repeat (5) step();
        check("prst_vld_count", 64'(vld_count), 64'd1);
        exp_q.push_back(entry_val(0));
        bus.i_pop = 1'b1;
        step();
        bus.i_pop = 1'b0;
        drain();
        check("prst_restart_count", 64'(vld_count), 64'd2);

        // write and pop to entry 0 in the same cycle: pop sees old data
        do_ptr_rst();
        exp_q.push_back(entry_val(0));
        bus.i_wr_en = 1'b1;
        bus.i_wr_addr = '0;
        bus.i_wr_data = 16'hBEEF;
        bus.i_pop = 1'b1;
        step();
        bus.i_wr_en = 1'b0;
        bus.i_pop = 1'b0;
        model_mem[0] = 16'hBEEF;
        drain();
        readback(0, 'hBEEF);
        do_ptr_rst();
        exp_q.push_back(entry_val(0));
        bus.i_pop = 1'b1;
        step();
        bus.i_pop = 1'b0;
        drain();
        wr(0, 0);

        // threshold lowered from 7 to 2 while rptr=1
        do_ptr_rst();
        load_thsh(7, 1'b0, 0);
        vld_count = 0;
        exp_q.push_back(entry_val(0));
        bus.i_pop = 1'b1;
        step();
        bus.i_pop = 1'b0;
        load_thsh(2, 1'b0, 0);
        exp_q.push_back(entry_val(1));
        exp_q.push_back(entry_val(2));
        bus.i_pop = 1'b1;
        step();
        check("thchg_empty_at1", 64'(bus.o_is_empty), 64'd0);
        step();
        check("thchg_empty_at2", 64'(bus.o_is_empty), 64'd1);
        bus.i_pop = 1'b0;
        drain();
        check("thchg_vld_count", 64'(vld_count), 64'd3);

        // async reset mid-stream, between clock edges
        do_ptr_rst();
        readback(5, 5);
        load_thsh(1, 1'b1, 5);
        for (int p = 0; p < 3; p++) begin
            exp_q.push_back(entry_val(0));
            exp_q.push_back(entry_val(1));
        end
        bus.i_pop = 1'b1;
        repeat (5) step();
        check("pre_reset_pass_cnt", 64'(bus.o_pass_cnt), 64'd2);
        #3 rst_n = 1'b0;
        bus.i_pop = 1'b0;
        exp_q.delete();
        #2;
        check_outputs_zero("async_reset");
        step();
        rst_n = 1'b1;
        step();
        vld_count = 0;
        exp_q.push_back(entry_val(0));
        bus.i_pop = 1'b1;
        step();
        bus.i_pop = 1'b0;
        check("post_reset_thsh0_empty", 64'(bus.o_is_empty), 64'd1);
        drain();
        check("post_reset_vld_count", 64'(vld_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
